// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the open-drain
// clock/data pair, exposing pull-low enables only; the top level builds the tri-states.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk_100mHz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       tx_noack,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       rx_inhibit
);

    // state     | meaning
    // IDLE      | lines released, ready for a byte
    // INHIBIT   | clock held low for INHIBIT_CYCLES
    // RTS       | start bit on data, clock released, waiting for first device fall
    // SHIFT     | data bits, parity and stop presented one per device fall
    // ACK       | waiting for fall 11 to sample the device ack
    // WAIT_IDLE | waiting for both lines high before reporting done
    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W  = $clog2(FILTER_LEN + 1);

    localparam logic [INH_W-1:0]  INH_LOAD  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LOAD = TOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(FILTER_LEN - 1);

    logic [1:0]        clk_sync_q;
    logic [1:0]        data_sync_q;
    logic              clk_filt_q;
    logic [FLT_W-1:0]  flt_cnt_q;
    logic              fall_q;

    state_t            state_q;
    logic [9:0]        byte_sh_q;
    logic [3:0]        bit_cnt_q;
    logic [INH_W-1:0]  inh_cnt_q;
    logic [TOUT_W-1:0] tout_cnt_q;
    logic              tx_ready_q;
    logic              tx_done_q;
    logic              tx_error_q;
    logic              tx_noack_q;
    logic              clk_drv_q;
    logic              data_drv_q;
    logic              rx_inhibit_q;

    // Lines idle high, so synchronizers and the filtered level reset to 1.
    always_ff @(posedge clk_100mHz) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            flt_cnt_q   <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                flt_cnt_q  <= '0;
                clk_filt_q <= clk_sync_q[1];
                fall_q     <= clk_filt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mHz) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_sh_q    <= '0;
            bit_cnt_q    <= '0;
            inh_cnt_q    <= '0;
            tout_cnt_q   <= '0;
            tx_ready_q   <= 1'b1;
            tx_done_q    <= 1'b0;
            tx_error_q   <= 1'b0;
            tx_noack_q   <= 1'b0;
            clk_drv_q    <= 1'b0;
            data_drv_q   <= 1'b0;
            rx_inhibit_q <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            tx_noack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_drv_q    <= 1'b0;
                    data_drv_q   <= 1'b0;
                    rx_inhibit_q <= 1'b0;
                    tx_ready_q   <= 1'b1;
                    if (tx_valid && tx_ready_q) begin
                        // Frame tail after the start bit: data LSB first, odd parity, stop.
                        byte_sh_q    <= {1'b1, ~^tx_data, tx_data};
                        bit_cnt_q    <= '0;
                        inh_cnt_q    <= INH_LOAD;
                        tx_ready_q   <= 1'b0;
                        rx_inhibit_q <= 1'b1;
                        clk_drv_q    <= 1'b1;
                        state_q      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == '0) begin
                        clk_drv_q  <= 1'b0;
                        data_drv_q <= 1'b1;
                        tout_cnt_q <= TOUT_LOAD;
                        bit_cnt_q  <= '0;
                        state_q    <= S_RTS;
                    end else begin
                        inh_cnt_q <= inh_cnt_q - 1'b1;
                    end
                end
                S_RTS, S_SHIFT: begin
                    if (fall_q) begin
                        // The stop bit shifts out as a 1, which releases the data line.
                        data_drv_q <= ~byte_sh_q[0];
                        byte_sh_q  <= {1'b1, byte_sh_q[9:1]};
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        tout_cnt_q <= TOUT_LOAD;
                        state_q    <= (bit_cnt_q == 4'd9) ? S_ACK : S_SHIFT;
                    end else if (tout_cnt_q == '0) begin
                        tx_error_q   <= 1'b1;
                        clk_drv_q    <= 1'b0;
                        data_drv_q   <= 1'b0;
                        rx_inhibit_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        tout_cnt_q <= tout_cnt_q - 1'b1;
                    end
                end
                S_ACK: begin
                    if (fall_q) begin
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        tout_cnt_q <= TOUT_LOAD;
                        if (data_sync_q[1]) begin
                            tx_error_q   <= 1'b1;
                            tx_noack_q   <= 1'b1;
                            clk_drv_q    <= 1'b0;
                            data_drv_q   <= 1'b0;
                            rx_inhibit_q <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT_IDLE;
                        end
                    end else if (tout_cnt_q == '0) begin
                        tx_error_q   <= 1'b1;
                        clk_drv_q    <= 1'b0;
                        data_drv_q   <= 1'b0;
                        rx_inhibit_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        tout_cnt_q <= tout_cnt_q - 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_sync_q[1] && data_sync_q[1]) begin
                        tx_done_q    <= 1'b1;
                        clk_drv_q    <= 1'b0;
                        data_drv_q   <= 1'b0;
                        rx_inhibit_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else if (tout_cnt_q == '0) begin
                        tx_error_q   <= 1'b1;
                        clk_drv_q    <= 1'b0;
                        data_drv_q   <= 1'b0;
                        rx_inhibit_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        tout_cnt_q <= tout_cnt_q - 1'b1;
                    end
                end
                default: begin
                    clk_drv_q    <= 1'b0;
                    data_drv_q   <= 1'b0;
                    rx_inhibit_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready           = tx_ready_q;
    assign tx_done            = tx_done_q;
    assign tx_error           = tx_error_q;
    assign tx_noack           = tx_noack_q;
    assign ps2_clk_drive_low  = clk_drv_q;
    assign ps2_data_drive_low = data_drv_q;
    assign rx_inhibit         = rx_inhibit_q;

endmodule
